img_rd_arbiter: RTL and testbench



---
 rtl/img_rd_arbiter.sv | 279 +++++++++++++++++++++++++++
 tb/tb_img_rd_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : img_rd_arbiter
// Summary  : Read front-end for the image memory pool. Arbitrates REQ_NUM
//            requesters onto IMG_GRP_NUM group read buses, tracks a fixed
//            BRAM read latency and returns in-order data to each requester
//            through a per-requester FWFT FIFO guarded by credit admission.
// Config   : IMG_RD_FIXED_PRIO_EN - when defined, requester 0 always wins any
//            group it targets; the others round-robin among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module img_rd_arbiter #(
  parameter int REQ_NUM         = 3,
  parameter int IMG_GRP_NUM     = 3,
  parameter int ROW_PARA        = 4,
  parameter int CHL_PARA        = 8,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int BANK_UNIT_WIDTH = 8,
  parameter int RD_LATENCY      = 2,
  parameter int OUT_FIFO_DEPTH  = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic [REQ_NUM-1:0]                                     req_valid_i,
  input  logic [REQ_NUM*IMG_GRP_NUM-1:0]                         req_group_id_i,
  input  logic [REQ_NUM*ROW_PARA-1:0]                            req_bank_en_i,
  input  logic [REQ_NUM*ROW_PARA*BANK_ADDR_WIDTH-1:0]            req_addr_i,
  output logic [REQ_NUM-1:0]                                     req_ready_o,
  output logic [REQ_NUM-1:0]                                     rsp_valid_o,
  output logic [REQ_NUM*ROW_PARA*CHL_PARA*BANK_UNIT_WIDTH-1:0]   rsp_data_o,
  input  logic [REQ_NUM-1:0]                                     rsp_ready_i,
  output logic [IMG_GRP_NUM*ROW_PARA-1:0]                        grp_read_bank_en_o,
  output logic [IMG_GRP_NUM*ROW_PARA*BANK_ADDR_WIDTH-1:0]        grp_read_addr_o,
  input  logic [IMG_GRP_NUM*ROW_PARA*CHL_PARA*BANK_UNIT_WIDTH-1:0] grp_read_data_i,
  output logic [REQ_NUM-1:0]                                     err_o
);

  localparam int AW     = ROW_PARA * BANK_ADDR_WIDTH;
  localparam int LANE_W = CHL_PARA * BANK_UNIT_WIDTH;
  localparam int DW     = ROW_PARA * LANE_W;
  localparam int PIPE_D = RD_LATENCY + 1;
  localparam int PTR_W  = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int RR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int GI_W   = (IMG_GRP_NUM > 1) ? $clog2(IMG_GRP_NUM) : 1;

  localparam logic [CNT_W:0]  DEPTH_C  = (CNT_W + 1)'(OUT_FIFO_DEPTH);
  localparam logic [RR_W-1:0] LAST_REQ = RR_W'(REQ_NUM - 1);

  // Unpacked views of the flattened buses
  logic [IMG_GRP_NUM-1:0] gid    [REQ_NUM];
  logic [ROW_PARA-1:0]    rbe    [REQ_NUM];
  logic [AW-1:0]          raddr  [REQ_NUM];
  logic [DW-1:0]          gdata  [IMG_GRP_NUM];

  // Request decode and arbitration
  logic [REQ_NUM-1:0]     id_legal;
  logic [REQ_NUM-1:0]     eligible;
  logic [REQ_NUM-1:0]     granted;
  logic [REQ_NUM-1:0]     accept;
  logic [GI_W-1:0]        id_idx   [REQ_NUM];
  logic [RR_W-1:0]        rr_ptr   [IMG_GRP_NUM];
  logic [IMG_GRP_NUM-1:0] grp_hit;
  logic [RR_W-1:0]        grp_sel  [IMG_GRP_NUM];
  logic [ROW_PARA-1:0]    grp_be   [IMG_GRP_NUM];
  logic [AW-1:0]          grp_addr [IMG_GRP_NUM];

  // Latency pipe: {valid, group, bank_en, illegal} per stage
  logic [PIPE_D-1:0]      pv   [REQ_NUM];
  logic [PIPE_D-1:0]      pill [REQ_NUM];
  logic [GI_W-1:0]        pg   [REQ_NUM][PIPE_D];
  logic [ROW_PARA-1:0]    pbe  [REQ_NUM][PIPE_D];

  // Response FIFOs and credit tracking
  logic [REQ_NUM-1:0]     push;
  logic [REQ_NUM-1:0]     pop;
  logic [DW-1:0]          push_data [REQ_NUM];
  logic [CNT_W-1:0]       inflight  [REQ_NUM];
  logic [CNT_W-1:0]       fcnt      [REQ_NUM];
  logic [PTR_W-1:0]       wptr      [REQ_NUM];
  logic [PTR_W-1:0]       rptr      [REQ_NUM];
  logic [DW-1:0]          mem       [REQ_NUM][OUT_FIFO_DEPTH];
  logic [REQ_NUM-1:0]     err;

  generate
    for (genvar r = 0; r < REQ_NUM; r++) begin : g_req
      assign gid[r]   = req_group_id_i[r*IMG_GRP_NUM +: IMG_GRP_NUM];
      assign rbe[r]   = req_bank_en_i[r*ROW_PARA +: ROW_PARA];
      assign raddr[r] = req_addr_i[r*AW +: AW];
      assign req_ready_o[r] = accept[r];
      assign rsp_valid_o[r] = (fcnt[r] != '0);
      // Data is forced to zero while empty so the bus is quiet after reset
      assign rsp_data_o[r*DW +: DW] = (fcnt[r] != '0) ? mem[r][rptr[r]] : '0;
      assign err_o[r] = err[r];
    end
    for (genvar g = 0; g < IMG_GRP_NUM; g++) begin : g_grp
      assign gdata[g] = grp_read_data_i[g*DW +: DW];
      assign grp_read_bank_en_o[g*ROW_PARA +: ROW_PARA] = grp_be[g];
      assign grp_read_addr_o[g*AW +: AW] = grp_addr[g];
    end
  endgenerate

  // Decode one-hot group id and compute credit-based eligibility
  always_comb begin
    int ones;
    ones = 0;
    for (int r = 0; r < REQ_NUM; r++) begin
      id_idx[r] = '0;
      ones      = 0;
      for (int g = 0; g < IMG_GRP_NUM; g++) begin
        if (gid[r][g]) begin
          id_idx[r] = GI_W'(g);
          ones      = ones + 1;
        end
      end
      id_legal[r] = (ones == 1);
      eligible[r] = req_valid_i[r] &&
                    (({1'b0, fcnt[r]} + {1'b0, inflight[r]}) < DEPTH_C);
    end
  end

  // Per-group arbitration: first legal eligible requester from rr_ptr onward
  always_comb begin
    int r;
    r       = 0;
    grp_hit = '0;
    for (int g = 0; g < IMG_GRP_NUM; g++) begin
      grp_sel[g] = '0;
`ifdef IMG_RD_FIXED_PRIO_EN
      if (eligible[0] && id_legal[0] && gid[0][g]) begin
        grp_hit[g] = 1'b1;
        grp_sel[g] = '0;
      end
      for (int k = 0; k < REQ_NUM; k++) begin
        r = (int'(rr_ptr[g]) + k) % REQ_NUM;
        if (!grp_hit[g] && (r != 0) && eligible[r] && id_legal[r] && gid[r][g]) begin
          grp_hit[g] = 1'b1;
          grp_sel[g] = RR_W'(r);
        end
      end
`else
      for (int k = 0; k < REQ_NUM; k++) begin
        r = (int'(rr_ptr[g]) + k) % REQ_NUM;
        if (!grp_hit[g] && eligible[r] && id_legal[r] && gid[r][g]) begin
          grp_hit[g] = 1'b1;
          grp_sel[g] = RR_W'(r);
        end
      end
`endif
    end
  end

  // Accept: granted legal requests plus eligible illegal ones (no memory access)
  always_comb begin
    for (int r = 0; r < REQ_NUM; r++) begin
      granted[r] = 1'b0;
      for (int g = 0; g < IMG_GRP_NUM; g++) begin
        if (grp_hit[g] && (grp_sel[g] == RR_W'(r))) begin
          granted[r] = 1'b1;
        end
      end
      accept[r] = rst_n & (granted[r] | (eligible[r] & ~id_legal[r]));
    end
  end

  // Group read registers and round-robin pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < IMG_GRP_NUM; g++) begin
        rr_ptr[g]   <= '0;
        grp_be[g]   <= '0;
        grp_addr[g] <= '0;
      end
    end else begin
      for (int g = 0; g < IMG_GRP_NUM; g++) begin
        if (grp_hit[g]) begin
          grp_be[g]   <= rbe[grp_sel[g]];
          grp_addr[g] <= raddr[grp_sel[g]];
`ifdef IMG_RD_FIXED_PRIO_EN
          if (grp_sel[g] != '0) begin
            rr_ptr[g] <= (grp_sel[g] == LAST_REQ) ? '0 : grp_sel[g] + RR_W'(1);
          end
`else
          rr_ptr[g] <= (grp_sel[g] == LAST_REQ) ? '0 : grp_sel[g] + RR_W'(1);
`endif
        end else begin
          grp_be[g] <= '0;
        end
      end
    end
  end

  // Latency pipe shifts the accept descriptor toward the data sample point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        pv[r]   <= '0;
        pill[r] <= '0;
        for (int d = 0; d < PIPE_D; d++) begin
          pg[r][d]  <= '0;
          pbe[r][d] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < REQ_NUM; r++) begin
        pv[r]     <= {pv[r][PIPE_D-2:0], accept[r]};
        pill[r]   <= {pill[r][PIPE_D-2:0], accept[r] & ~id_legal[r]};
        pg[r][0]  <= id_idx[r];
        pbe[r][0] <= rbe[r];
        for (int d = 1; d < PIPE_D; d++) begin
          pg[r][d]  <= pg[r][d-1];
          pbe[r][d] <= pbe[r][d-1];
        end
      end
    end
  end

  // FIFO write data: sampled group data with disabled bank lanes zeroed
  always_comb begin
    for (int r = 0; r < REQ_NUM; r++) begin
      push[r]      = pv[r][RD_LATENCY];
      pop[r]       = (fcnt[r] != '0) && rsp_ready_i[r];
      push_data[r] = '0;
      if (pv[r][RD_LATENCY] && !pill[r][RD_LATENCY]) begin
        for (int b = 0; b < ROW_PARA; b++) begin
          if (pbe[r][RD_LATENCY][b]) begin
            push_data[r][b*LANE_W +: LANE_W] = gdata[pg[r][RD_LATENCY]][b*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // Credit counters, FIFO pointers/occupancy and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        inflight[r] <= '0;
        fcnt[r]     <= '0;
        wptr[r]     <= '0;
        rptr[r]     <= '0;
      end
      err <= '0;
    end else begin
      for (int r = 0; r < REQ_NUM; r++) begin
        if (accept[r] && !push[r]) begin
          inflight[r] <= inflight[r] + CNT_W'(1);
        end else if (!accept[r] && push[r]) begin
          inflight[r] <= inflight[r] - CNT_W'(1);
        end
        if (push[r]) begin
          wptr[r] <= wptr[r] + PTR_W'(1);
        end
        if (pop[r]) begin
          rptr[r] <= rptr[r] + PTR_W'(1);
        end
        if (push[r] && !pop[r]) begin
          fcnt[r] <= fcnt[r] + CNT_W'(1);
        end else if (!push[r] && pop[r]) begin
          fcnt[r] <= fcnt[r] - CNT_W'(1);
        end
        if (accept[r] && !id_legal[r]) begin
          err[r] <= 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents are only observable through a valid head
  always_ff @(posedge clk) begin
    for (int r = 0; r < REQ_NUM; r++) begin
      if (push[r]) begin
        mem[r][wptr[r]] <= push_data[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_img_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_rd_arbiter
// Summary  : Self-checking bench for img_rd_arbiter. Directed scenarios and a
//            randomized phase are compared every cycle against a queue-based
//            transaction model of admission, arbitration and response return.
// Config   : IMG_RD_FIXED_PRIO_EN - model follows the fixed-priority variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_rd_arbiter;

  localparam int REQ   = 3;
  localparam int GRP   = 3;
  localparam int ROW   = 4;
  localparam int CHL   = 8;
  localparam int BAW   = 12;
  localparam int BUW   = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int AW    = ROW * BAW;
  localparam int LANE  = CHL * BUW;
  localparam int DW    = ROW * LANE;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [REQ-1:0]       req_valid_i;
  logic [REQ*GRP-1:0]   req_group_id_i;
  logic [REQ*ROW-1:0]   req_bank_en_i;
  logic [REQ*AW-1:0]    req_addr_i;
  logic [REQ-1:0]       req_ready_o;
  logic [REQ-1:0]       rsp_valid_o;
  logic [REQ*DW-1:0]    rsp_data_o;
  logic [REQ-1:0]       rsp_ready_i;
  logic [GRP*ROW-1:0]   grp_read_bank_en_o;
  logic [GRP*AW-1:0]    grp_read_addr_o;
  logic [GRP*DW-1:0]    grp_read_data_i;
  logic [REQ-1:0]       err_o;

  img_rd_arbiter #(
    .REQ_NUM(REQ), .IMG_GRP_NUM(GRP), .ROW_PARA(ROW), .CHL_PARA(CHL),
    .BANK_ADDR_WIDTH(BAW), .BANK_UNIT_WIDTH(BUW), .RD_LATENCY(LAT),
    .OUT_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_group_id_i(req_group_id_i),
    .req_bank_en_i(req_bank_en_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .grp_read_bank_en_o(grp_read_bank_en_o), .grp_read_addr_o(grp_read_addr_o),
    .grp_read_data_i(grp_read_data_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Stimulus state
  bit             s_v   [REQ];
  logic [GRP-1:0] s_gid [REQ];
  logic [ROW-1:0] s_be  [REQ];
  logic [AW-1:0]  s_addr[REQ];
  bit             s_rdy [REQ];
  logic [DW-1:0]  s_gd  [GRP];
  logic [REQ-1:0] obs_ready;

  // Transaction model
  typedef struct {
    int             due;
    int             r;
    int             g;
    logic [ROW-1:0] be;
    bit             ill;
  } pend_t;
  pend_t          pend[$];
  logic [DW-1:0]  fq[REQ][$];
  int             m_infl[REQ];
  int             m_rr[GRP];
  logic [ROW-1:0] m_be[GRP];
  logic [AW-1:0]  m_addr[GRP];
  bit             m_err[REQ];

  int cyc    = 0;
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++) v = {v[DW-33:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_aw();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic drive();
    for (int r = 0; r < REQ; r++) begin
      req_valid_i[r]               = s_v[r];
      req_group_id_i[r*GRP +: GRP] = s_gid[r];
      req_bank_en_i[r*ROW +: ROW]  = s_be[r];
      req_addr_i[r*AW +: AW]       = s_addr[r];
      rsp_ready_i[r]               = s_rdy[r];
    end
    for (int g = 0; g < GRP; g++) grp_read_data_i[g*DW +: DW] = s_gd[g];
  endtask

  task automatic clear_req();
    for (int r = 0; r < REQ; r++) begin
      s_v[r] = 1'b0; s_gid[r] = '0; s_be[r] = '0; s_addr[r] = '0;
    end
  endtask

  task automatic set_req(input int r, input logic [GRP-1:0] gid,
                         input logic [ROW-1:0] be, input logic [AW-1:0] a);
    s_v[r] = 1'b1; s_gid[r] = gid; s_be[r] = be; s_addr[r] = a;
  endtask

  task automatic model_clear();
    for (int r = 0; r < REQ; r++) begin
      fq[r].delete(); m_infl[r] = 0; m_err[r] = 1'b0;
    end
    for (int g = 0; g < GRP; g++) begin
      m_rr[g] = 0; m_be[g] = '0; m_addr[g] = '0;
    end
    pend.delete();
  endtask

  // One clock cycle: drive, compare against the model, advance the model
  task automatic tick();
    bit            elig[REQ];
    bit            legal[REQ];
    bit            acc[REQ];
    int            gi[REQ];
    int            w;
    int            r;
    logic [DW-1:0] d;
    for (int g = 0; g < GRP; g++) s_gd[g] = rand_dw();
    drive();
    #2;
    for (int q = 0; q < REQ; q++) begin
      d = (fq[q].size() > 0) ? fq[q][0] : '0;
      chk($sformatf("rsp_valid[%0d]", q), rsp_valid_o[q], fq[q].size() > 0);
      chk($sformatf("rsp_data[%0d]", q), rsp_data_o[q*DW +: DW], d);
      chk($sformatf("err[%0d]", q), err_o[q], m_err[q]);
    end
    for (int g = 0; g < GRP; g++) begin
      chk($sformatf("grp_be[%0d]", g), grp_read_bank_en_o[g*ROW +: ROW], m_be[g]);
      chk($sformatf("grp_addr[%0d]", g), grp_read_addr_o[g*AW +: AW], m_addr[g]);
    end
    for (int q = 0; q < REQ; q++) begin
      elig[q]  = s_v[q] && ((fq[q].size() + m_infl[q]) < DEPTH);
      legal[q] = ($countones(s_gid[q]) == 1);
      gi[q]    = 0;
      for (int g = 0; g < GRP; g++) if (s_gid[q][g]) gi[q] = g;
      acc[q]   = 1'b0;
    end
    for (int g = 0; g < GRP; g++) begin
      w = -1;
`ifdef IMG_RD_FIXED_PRIO_EN
      if (elig[0] && legal[0] && gi[0] == g) w = 0;
      for (int k = 0; k < REQ; k++) begin
        r = (m_rr[g] + k) % REQ;
        if (w < 0 && r != 0 && elig[r] && legal[r] && gi[r] == g) w = r;
      end
      if (w > 0) m_rr[g] = (w + 1) % REQ;
`else
      for (int k = 0; k < REQ; k++) begin
        r = (m_rr[g] + k) % REQ;
        if (w < 0 && elig[r] && legal[r] && gi[r] == g) w = r;
      end
      if (w >= 0) m_rr[g] = (w + 1) % REQ;
`endif
      if (w >= 0) begin
        acc[w]    = 1'b1;
        m_be[g]   = s_be[w];
        m_addr[g] = s_addr[w];
        pend.push_back('{cyc + 1 + LAT, w, g, s_be[w], 1'b0});
      end else begin
        m_be[g] = '0;
      end
    end
    for (int q = 0; q < REQ; q++) begin
      if (elig[q] && !legal[q]) begin
        acc[q]   = 1'b1;
        m_err[q] = 1'b1;
        pend.push_back('{cyc + 1 + LAT, q, 0, '0, 1'b1});
      end
    end
    obs_ready = req_ready_o;
    for (int q = 0; q < REQ; q++) chk($sformatf("req_ready[%0d]", q), req_ready_o[q], acc[q]);
    for (int q = 0; q < REQ; q++) begin
      if (fq[q].size() > 0 && s_rdy[q]) void'(fq[q].pop_front());
      if (acc[q]) m_infl[q]++;
    end
    while (pend.size() > 0 && pend[0].due == cyc) begin
      d = pend[0].ill ? '0 : s_gd[pend[0].g];
      for (int b = 0; b < ROW; b++) if (!pend[0].be[b]) d[b*LANE +: LANE] = '0;
      fq[pend[0].r].push_back(d);
      m_infl[pend[0].r]--;
      void'(pend.pop_front());
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once
  task automatic do_reset();
    for (int r = 0; r < REQ; r++) set_req(r, GRP'(1) << r, '1, rand_aw());
    drive();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready_o, '0);
    chk("rst_rsp_valid", rsp_valid_o, '0);
    chk("rst_rsp_data", rsp_data_o, '0);
    chk("rst_grp_be", grp_read_bank_en_o, '0);
    chk("rst_grp_addr", grp_read_addr_o, '0);
    chk("rst_err", err_o, '0);
    model_clear();
    clear_req();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int cnt[REQ];
    int total;
    int budget;
    clear_req();
    for (int r = 0; r < REQ; r++) s_rdy[r] = 1'b1;
    for (int g = 0; g < GRP; g++) s_gd[g] = '0;
    drive();
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_rsp_valid", rsp_valid_o, '0);
    chk("init_grp_be", grp_read_bank_en_o, '0);
    chk("init_grp_addr", grp_read_addr_o, '0);
    chk("init_err", err_o, '0);
    rst_n = 1'b1;
    tick();

    // Single read: r0 -> group 1, all banks
    set_req(0, 3'b010, 4'hF, 48'hA5A_123_456_789);
    tick();
    chk("single_grp1_be", grp_read_bank_en_o[1*ROW +: ROW], 4'hF);
    chk("single_other_be", {grp_read_bank_en_o[2*ROW +: ROW], grp_read_bank_en_o[0 +: ROW]}, '0);
    clear_req();
    lat = 1;
    while (rsp_valid_o[0] !== 1'b1 && lat < 20) begin tick(); lat++; end
    chk("single_latency", lat, 2 + LAT);
    repeat (3) tick();

    // Contention: everyone targets group 0
    for (int r = 0; r < REQ; r++) cnt[r] = 0;
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < REQ; r++) set_req(r, 3'b001, 4'($urandom), rand_aw());
      tick();
      for (int r = 0; r < REQ; r++) cnt[r] += obs_ready[r];
    end
`ifndef IMG_RD_FIXED_PRIO_EN
    for (int r = 0; r < REQ; r++) chk($sformatf("contend_grants[%0d]", r), cnt[r], 4);
`endif
    clear_req();
    repeat (8) tick();

    // Back-pressure on r1
    s_rdy[1] = 1'b0;
    total = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(1, 3'b100, 4'($urandom), rand_aw());
      tick();
      total += obs_ready[1];
    end
    chk("bp_first_accepts", total, DEPTH);
    cnt[1] = 0;
    s_rdy[1] = 1'b1;
    set_req(1, 3'b100, 4'($urandom), rand_aw());
    tick();
    cnt[1] += obs_ready[1];
    s_rdy[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_req(1, 3'b100, 4'($urandom), rand_aw());
      tick();
      cnt[1] += obs_ready[1];
    end
    chk("bp_after_pop", cnt[1], 1);
    total += cnt[1];
    s_rdy[1] = 1'b1;
    budget = 0;
    while (total < 20 && budget < 200) begin
      set_req(1, 3'b100, 4'($urandom), rand_aw());
      tick();
      total += obs_ready[1];
      budget++;
    end
    chk("bp_total", total, 20);
    clear_req();
    repeat (8) tick();

    // Partial banks
    set_req(2, 3'b001, 4'b0101, rand_aw());
    tick();
    clear_req();
    lat = 1;
    while (rsp_valid_o[2] !== 1'b1 && lat < 20) begin tick(); lat++; end
    chk("partial_latency", lat, 2 + LAT);
    chk("partial_lane1", rsp_data_o[2*DW + 1*LANE +: LANE], '0);
    chk("partial_lane3", rsp_data_o[2*DW + 3*LANE +: LANE], '0);
    repeat (4) tick();

    // Illegal group ids
    set_req(0, 3'b000, 4'hF, rand_aw());
    tick();
    chk("illegal_zero_accept", obs_ready[0], 1'b1);
    set_req(0, 3'b011, 4'hF, rand_aw());
    tick();
    chk("illegal_multi_accept", obs_ready[0], 1'b1);
    clear_req();
    chk("illegal_err", err_o[0], 1'b1);
    chk("illegal_grp_idle", grp_read_bank_en_o, '0);
    repeat (6) tick();

    // Mid-stream reset with three responses in flight
    set_req(0, 3'b001, 4'hF, rand_aw());
    set_req(1, 3'b010, 4'hF, rand_aw());
    set_req(2, 3'b100, 4'hF, rand_aw());
    tick();
    clear_req();
    tick();
    do_reset();
    repeat (8) tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      for (int r = 0; r < REQ; r++) begin
        s_v[r] = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 19) == 0) s_gid[r] = GRP'($urandom);
        else s_gid[r] = GRP'(1) << $urandom_range(0, GRP - 1);
        s_be[r]   = ROW'($urandom);
        s_addr[r] = rand_aw();
        s_rdy[r]  = ($urandom_range(0, 9) < 7);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
